// File: rtl/qos_grant_scheduler.sv
// QoS grant scheduler: 16-entry table, one registered grant per 2 cycles, highest effective QoS wins.
// Latency: request accepted at edge E can be offered after E+1; offer holds while gnt_rdy=0, duplicate IDs stall req_rdy.
module qos_grant_scheduler #(
  parameter int NUM_ID    = 16,
  parameter int ID_W      = 4,
  parameter int QOS_W     = 3,
  parameter int AGE_LIMIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [ID_W-1:0]  req_id,
  input  logic [QOS_W-1:0] req_qos,
  output logic             gnt_vld,
  input  logic             gnt_rdy,
  output logic [ID_W-1:0]  gnt_id,
  output logic [QOS_W-1:0] gnt_qos,
  output logic [ID_W:0]    pend_cnt,
  output logic [QOS_W-1:0] max_qos
);
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  localparam logic [QOS_W-1:0] QOS_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_LIMIT);

  typedef struct packed {
    logic             pend;
    logic [QOS_W-1:0] qos;
    logic [AGE_W-1:0] age;
  } entry_t;

  typedef enum logic {IDLE, OFFER} state_t;

  entry_t [NUM_ID-1:0]             tbl;
  state_t                          state, state_nxt;
  logic   [ID_W-1:0]               rr_ptr;
  logic                            load, hs, acc;
  logic   [NUM_ID-1:0]             aged;
  logic   [NUM_ID-1:0][QOS_W-1:0]  eff;
  logic                            best_vld;
  logic   [ID_W-1:0]               best_id, scan_id;
  logic   [QOS_W:0]                best_key;
  logic   [QOS_W-1:0]              max_eff;

  assign req_rdy = !tbl[req_id].pend;
  assign acc     = req_vld && req_rdy;
  assign gnt_vld = (state == OFFER);
  assign hs      = gnt_vld && gnt_rdy;
  assign max_qos = max_eff;

  always_comb begin
    for (int i = 0; i < NUM_ID; i++) begin
      aged[i] = (tbl[i].age == AGE_SAT);
      eff[i]  = aged[i] ? QOS_MAX : tbl[i].qos;
    end
  end

  // Key {eff, aged} orders by eff then aged; scanning from rr_ptr with strict '>' keeps the first tie.
  always_comb begin
    best_vld = 1'b0;
    best_id  = '0;
    best_key = '0;
    scan_id  = '0;
    for (int i = 0; i < NUM_ID; i++) begin
      scan_id = rr_ptr + ID_W'(i);
      if (tbl[scan_id].pend && (!best_vld || {eff[scan_id], aged[scan_id]} > best_key)) begin
        best_vld = 1'b1;
        best_id  = scan_id;
        best_key = {eff[scan_id], aged[scan_id]};
      end
    end
  end

  always_comb begin
    max_eff = '0;
    for (int i = 0; i < NUM_ID; i++) begin
      if (tbl[i].pend && eff[i] > max_eff) max_eff = eff[i];
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (best_vld) begin
          state_nxt = OFFER;
          load      = 1'b1;
        end
      end
      OFFER: begin
        if (gnt_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_id  <= '0;
      gnt_qos <= '0;
    end else if (load) begin
      gnt_id  <= best_id;
      gnt_qos <= tbl[best_id].qos;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt <= '0;
    end else begin
      case ({acc, hs})
        2'b10:   pend_cnt <= pend_cnt + (ID_W+1)'(1);
        2'b01:   pend_cnt <= pend_cnt - (ID_W+1)'(1);
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

  // Accept is applied after the handshake update so a fresh entry always starts at age 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl    <= '0;
      rr_ptr <= '0;
    end else begin
      if (hs) begin
        for (int i = 0; i < NUM_ID; i++) begin
          if (ID_W'(i) == gnt_id) begin
            tbl[i].pend <= 1'b0;
            tbl[i].age  <= '0;
          end else if (tbl[i].pend && !aged[i]) begin
            tbl[i].age <= tbl[i].age + AGE_W'(1);
          end
        end
        rr_ptr <= gnt_id + ID_W'(1);
      end
      if (acc) begin
        tbl[req_id].pend <= 1'b1;
        tbl[req_id].qos  <= req_qos;
        tbl[req_id].age  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_qos_grant_scheduler.sv
// Bench for qos_grant_scheduler: directed scenarios plus random traffic against a table-level reference model.
module tb_qos_grant_scheduler;
  localparam int LIM = 3;

  logic       clk, rst_n, req_vld, gnt_rdy;
  logic [3:0] req_id;
  logic [2:0] req_qos;
  logic       req_rdy, gnt_vld;
  logic [3:0] gnt_id;
  logic [2:0] gnt_qos;
  logic [4:0] pend_cnt;
  logic [2:0] max_qos;

  qos_grant_scheduler #(.NUM_ID(16), .ID_W(4), .QOS_W(3), .AGE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy), .req_id(req_id),
    .req_qos(req_qos), .gnt_vld(gnt_vld), .gnt_rdy(gnt_rdy), .gnt_id(gnt_id),
    .gnt_qos(gnt_qos), .pend_cnt(pend_cnt), .max_qos(max_qos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain table of pending IDs plus the current offer.
  bit m_pend[16];
  int m_qos[16];
  int m_age[16];
  int m_rr;
  bit m_ovld;
  int m_oid, m_oqos;
  int got_id[$];
  int got_qos[$];

  task automatic m_reset();
    for (int j = 0; j < 16; j++) begin
      m_pend[j] = 0; m_qos[j] = 0; m_age[j] = 0;
    end
    m_rr = 0; m_ovld = 0; m_oid = 0; m_oqos = 0;
  endtask

  function automatic int m_count();
    int n = 0;
    for (int j = 0; j < 16; j++) if (m_pend[j]) n++;
    return n;
  endfunction

  function automatic int m_eff(int j);
    return (m_age[j] == LIM) ? 7 : m_qos[j];
  endfunction

  function automatic int m_max();
    int m = 0;
    for (int j = 0; j < 16; j++) if (m_pend[j] && m_eff(j) > m) m = m_eff(j);
    return m;
  endfunction

  // Score = 2*eff + aged; the first candidate met walking up from rr keeps ties.
  function automatic int m_pick();
    int best = -1;
    int bs = -1;
    int j, s;
    for (int k = 0; k < 16; k++) begin
      j = (m_rr + k) % 16;
      if (m_pend[j]) begin
        s = 2 * m_eff(j) + ((m_age[j] == LIM) ? 1 : 0);
        if (s > bs) begin bs = s; best = j; end
      end
    end
    return best;
  endfunction

  task automatic tick();
    bit hs, acc;
    int w;
    hs  = m_ovld && gnt_rdy;
    acc = req_vld && !m_pend[req_id];
    if (gnt_vld && gnt_rdy) begin
      got_id.push_back(int'(gnt_id));
      got_qos.push_back(int'(gnt_qos));
    end
    w = m_ovld ? -1 : m_pick();
    if (hs) begin
      for (int j = 0; j < 16; j++)
        if (m_pend[j] && j != m_oid && m_age[j] < LIM) m_age[j]++;
      m_pend[m_oid] = 0;
      m_age[m_oid]  = 0;
      m_rr   = (m_oid + 1) % 16;
      m_ovld = 0;
    end
    if (w >= 0) begin
      m_ovld = 1; m_oid = w; m_oqos = m_qos[w];
    end
    if (acc) begin
      m_pend[req_id] = 1; m_qos[req_id] = int'(req_qos); m_age[req_id] = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put(int id, int qos);
    req_vld = 1'b1; req_id = 4'(id); req_qos = 3'(qos);
    tick();
    req_vld = 1'b0;
  endtask

  task automatic drain();
    gnt_rdy = 1'b1; req_vld = 1'b0;
    for (int c = 0; c < 80 && (m_ovld || m_count() > 0); c++) tick();
  endtask

  task automatic test_reset();
    req_vld = 0; gnt_rdy = 0; req_id = 0; req_qos = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    m_reset();
    @(negedge clk); @(negedge clk);
    n_tests++; if (gnt_vld !== 1'b0) begin n_fail++; $display("FAIL reset_gnt_vld got %0b want 0", gnt_vld); end
    n_tests++; if (gnt_id !== 4'd0) begin n_fail++; $display("FAIL reset_gnt_id got %0d want 0", gnt_id); end
    n_tests++; if (gnt_qos !== 3'd0) begin n_fail++; $display("FAIL reset_gnt_qos got %0d want 0", gnt_qos); end
    n_tests++; if (pend_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_pend_cnt got %0d want 0", pend_cnt); end
    n_tests++; if (max_qos !== 3'd0) begin n_fail++; $display("FAIL reset_max_qos got %0d want 0", max_qos); end
    n_tests++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_req_rdy got %0b want 1", req_rdy); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // id0 is parked on offer first so ids 3, 7, 1 compete together; rr then sits at 1.
  task automatic test_basic();
    int exp_id[4];
    int exp_q[4];
    int g;
    exp_id = '{0, 1, 7, 3};
    exp_q  = '{0, 5, 5, 2};
    gnt_rdy = 0;
    put(0, 0); put(3, 2); put(7, 5); put(1, 5);
    got_id.delete(); got_qos.delete();
    gnt_rdy = 1;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_tests++;
      if (gnt_vld !== ((c % 2) == 0)) begin n_fail++; $display("FAIL basic_vld_toggle c=%0d got %0b want %0b", c, gnt_vld, (c % 2) == 0); end
      if (c % 2 == 1) begin
        n_tests++;
        if (pend_cnt !== 5'(3 - (c - 1) / 2)) begin n_fail++; $display("FAIL basic_pend_cnt c=%0d got %0d want %0d", c, pend_cnt, 3 - (c - 1) / 2); end
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      g = (k < got_id.size()) ? got_id[k] : -1;
      n_tests++; if (g != exp_id[k]) begin n_fail++; $display("FAIL basic_order k=%0d got %0d want %0d", k, g, exp_id[k]); end
      g = (k < got_qos.size()) ? got_qos[k] : -1;
      n_tests++; if (g != exp_q[k]) begin n_fail++; $display("FAIL basic_qos k=%0d got %0d want %0d", k, g, exp_q[k]); end
    end
  endtask

  task automatic test_rr_wrap();
    int exp_id[4];
    int g;
    exp_id = '{5, 9, 2, 5};
    gnt_rdy = 0;
    put(5, 0); put(2, 4); put(9, 4);
    got_id.delete(); got_qos.delete();
    req_vld = 1; req_id = 4'd5; req_qos = 3'd4;
    gnt_rdy = 1;
    for (int c = 0; c < 30 && (m_ovld || m_count() > 0 || req_vld); c++) begin
      if (got_id.size() >= 1 && m_pend[5]) req_vld = 0;
      #1;
      n_tests++;
      if (max_qos !== ((m_count() > 0) ? 3'd4 : 3'd0)) begin n_fail++; $display("FAIL rr_max_qos c=%0d got %0d want %0d", c, max_qos, (m_count() > 0) ? 4 : 0); end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      g = (k < got_id.size()) ? got_id[k] : -1;
      n_tests++; if (g != exp_id[k]) begin n_fail++; $display("FAIL rr_order k=%0d got %0d want %0d", k, g, exp_id[k]); end
    end
    n_tests++; if (max_qos !== 3'd0) begin n_fail++; $display("FAIL rr_max_qos_empty got %0d want 0", max_qos); end
  endtask

  task automatic test_backpressure();
    int g;
    gnt_rdy = 0;
    put(4, 6); put(8, 7);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_tests++; if (gnt_vld !== 1'b1) begin n_fail++; $display("FAIL bp_vld c=%0d got %0b want 1", c, gnt_vld); end
      n_tests++; if (gnt_id !== 4'd4) begin n_fail++; $display("FAIL bp_id c=%0d got %0d want 4", c, gnt_id); end
      n_tests++; if (gnt_qos !== 3'd6) begin n_fail++; $display("FAIL bp_qos c=%0d got %0d want 6", c, gnt_qos); end
      n_tests++; if (max_qos !== 3'd7) begin n_fail++; $display("FAIL bp_max_qos c=%0d got %0d want 7", c, max_qos); end
      n_tests++; if (pend_cnt !== 5'd2) begin n_fail++; $display("FAIL bp_pend_cnt c=%0d got %0d want 2", c, pend_cnt); end
      tick();
    end
    got_id.delete(); got_qos.delete();
    drain();
    g = (got_id.size() > 1) ? got_id[1] : -1;
    n_tests++; if (got_id.size() != 2 || got_id[0] != 4 || g != 8) begin n_fail++; $display("FAIL bp_order got n=%0d second=%0d want 4 then 8", got_id.size(), g); end
  endtask

  task automatic test_dup_stall();
    gnt_rdy = 0;
    put(6, 3);
    req_vld = 1; req_id = 4'd6; req_qos = 3'd1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL dup_stall_rdy c=%0d got %0b want 0", c, req_rdy); end
      tick();
    end
    n_tests++; if (gnt_vld !== 1'b1 || gnt_qos !== 3'd3) begin n_fail++; $display("FAIL dup_offer got vld=%0b qos=%0d want 1/3", gnt_vld, gnt_qos); end
    gnt_rdy = 1;
    tick();
    gnt_rdy = 0;
    #1;
    n_tests++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL dup_rdy_after_hs got %0b want 1", req_rdy); end
    n_tests++; if (pend_cnt !== 5'd0) begin n_fail++; $display("FAIL dup_cnt_after_hs got %0d want 0", pend_cnt); end
    tick();
    req_vld = 0;
    #1;
    n_tests++; if (pend_cnt !== 5'd1) begin n_fail++; $display("FAIL dup_cnt_after_acc got %0d want 1", pend_cnt); end
    n_tests++; if (gnt_vld !== 1'b0) begin n_fail++; $display("FAIL dup_vld_after_acc got %0b want 0", gnt_vld); end
    tick();
    #1;
    n_tests++; if (gnt_vld !== 1'b1 || gnt_id !== 4'd6 || gnt_qos !== 3'd1) begin n_fail++; $display("FAIL dup_regrant got vld=%0b id=%0d qos=%0d want 1/6/1", gnt_vld, gnt_id, gnt_qos); end
    drain();
  endtask

  // id1 holds the offer while id0 (qos0) is accepted; fresh qos7 ids keep arriving afterwards.
  task automatic test_aging();
    int p, cand;
    bit found;
    int g, gq;
    gnt_rdy = 0;
    put(1, 7); put(0, 0);
    got_id.delete(); got_qos.delete();
    gnt_rdy = 1;
    p = 2;
    for (int c = 0; c < 40; c++) begin
      found = 0;
      for (int k = 0; k < 15 && !found; k++) begin
        cand = ((p - 1 + k) % 15) + 1;
        if (!m_pend[cand]) begin
          req_id = 4'(cand); found = 1; p = cand % 15 + 1;
        end
      end
      req_vld = found; req_qos = 3'd7;
      tick();
    end
    req_vld = 0;
    drain();
    g  = (got_id.size() > 3) ? got_id[3] : -1;
    gq = (got_qos.size() > 3) ? got_qos[3] : -1;
    n_tests++; if (g != 0) begin n_fail++; $display("FAIL aging_slot got id %0d want 0", g); end
    n_tests++; if (gq != 0) begin n_fail++; $display("FAIL aging_qos got %0d want 0", gq); end
    n_tests++; if (pend_cnt !== 5'd0) begin n_fail++; $display("FAIL aging_drain got %0d want 0", pend_cnt); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if (c < 300) begin
        req_vld = ($urandom_range(3) != 0);
        gnt_rdy = ($urandom_range(4) == 0);
      end else begin
        req_vld = ($urandom_range(1) == 1);
        gnt_rdy = ($urandom_range(3) != 0);
      end
      req_id  = 4'($urandom_range(15));
      req_qos = 3'($urandom_range(7));
      #1;
      n_tests++; if (gnt_vld !== m_ovld) begin n_fail++; $display("FAIL rand_vld c=%0d got %0b want %0b", c, gnt_vld, m_ovld); end
      if (m_ovld) begin
        n_tests++; if (gnt_id !== 4'(m_oid)) begin n_fail++; $display("FAIL rand_id c=%0d got %0d want %0d", c, gnt_id, m_oid); end
        n_tests++; if (gnt_qos !== 3'(m_oqos)) begin n_fail++; $display("FAIL rand_qos c=%0d got %0d want %0d", c, gnt_qos, m_oqos); end
      end
      n_tests++; if (pend_cnt !== 5'(m_count())) begin n_fail++; $display("FAIL rand_cnt c=%0d got %0d want %0d", c, pend_cnt, m_count()); end
      n_tests++; if (max_qos !== 3'(m_max())) begin n_fail++; $display("FAIL rand_max c=%0d got %0d want %0d", c, max_qos, m_max()); end
      n_tests++; if (req_rdy !== !m_pend[req_id]) begin n_fail++; $display("FAIL rand_rdy c=%0d id=%0d got %0b want %0b", c, req_id, req_rdy, !m_pend[req_id]); end
      tick();
    end
    drain();
    n_tests++; if (pend_cnt !== 5'd0 || gnt_vld !== 1'b0) begin n_fail++; $display("FAIL rand_drain got cnt=%0d vld=%0b want 0/0", pend_cnt, gnt_vld); end
  endtask

  task automatic test_async_reset();
    gnt_rdy = 0;
    put(2, 1); put(11, 5); put(13, 3); put(14, 6);
    #2;
    n_tests++; if (gnt_vld !== 1'b1 || pend_cnt !== 5'd4) begin n_fail++; $display("FAIL ar_pre got vld=%0b cnt=%0d want 1/4", gnt_vld, pend_cnt); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (gnt_vld !== 1'b0) begin n_fail++; $display("FAIL ar_vld got %0b want 0", gnt_vld); end
    n_tests++; if (pend_cnt !== 5'd0) begin n_fail++; $display("FAIL ar_cnt got %0d want 0", pend_cnt); end
    n_tests++; if (max_qos !== 3'd0) begin n_fail++; $display("FAIL ar_max got %0d want 0", max_qos); end
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    put(9, 2);
    #1;
    n_tests++; if (gnt_vld !== 1'b0) begin n_fail++; $display("FAIL ar_lat_e got %0b want 0", gnt_vld); end
    tick();
    #1;
    n_tests++; if (gnt_vld !== 1'b1 || gnt_id !== 4'd9 || gnt_qos !== 3'd2) begin n_fail++; $display("FAIL ar_lat_e1 got vld=%0b id=%0d qos=%0d want 1/9/2", gnt_vld, gnt_id, gnt_qos); end
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_rr_wrap();
    test_backpressure();
    test_dup_stall();
    test_aging();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
